// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the multiply sequencer state type.
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiply sequencer that borrows the EX-stage ALU for one add per
// multiplier bit; transparent pass-through of the pipeline's ALU request when idle.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int EARLY_EXIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  input  logic [31:0] ExSrcA,
  input  logic [31:0] ExSrcB,
  input  logic [2:0]  ExALUControl,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  output logic [2:0]  ALUControl,
  input  logic [31:0] aluresult
);

  mul_state_t  state, state_d;
  logic [31:0] m, q, p;
  logic [4:0]  cnt;
  logic        last;

  // Last iteration: all 32 bits consumed, or no set multiplier bits remain above Q[0].
  assign last = (cnt == 5'd31) || ((EARLY_EXIT != 0) && (q[31:1] == 31'd0));

  always_comb begin
    state_d    = state;
    ready      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    SrcA       = p;
    SrcB       = '0;
    ALUControl = ALU_ADD;
    case (state)
      IDLE: begin
        ready      = 1'b1;
        busy       = 1'b0;
        SrcA       = ExSrcA;
        SrcB       = ExSrcB;
        ALUControl = ExALUControl;
        if (start) state_d = RUN;
      end
      RUN: begin
        SrcB = q[0] ? m : '0;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      m       <= '0;
      q       <= '0;
      p       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && start) begin
        m   <= op_a;
        q   <= op_b;
        p   <= '0;
        cnt <= '0;
      end else if (state == RUN) begin
        p   <= aluresult;
        m   <= m << 1;
        q   <= q >> 1;
        cnt <= cnt + 5'd1;
        if (last) product <= aluresult;
      end
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural ALU closing the loop.
module tb_alu_mul_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        ready, busy, done;
  logic [31:0] product;
  logic [31:0] ExSrcA, ExSrcB;
  logic [2:0]  ExALUControl;
  logic [31:0] SrcA, SrcB;
  logic [2:0]  ALUControl;
  logic [31:0] aluresult;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.EARLY_EXIT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .ready(ready), .busy(busy), .done(done), .product(product),
    .ExSrcA(ExSrcA), .ExSrcB(ExSrcB), .ExALUControl(ExALUControl),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .aluresult(aluresult)
  );

  // Stand-in for the core's alu instance.
  always_comb begin
    case (ALUControl)
      3'b000: aluresult = SrcA + SrcB;
      3'b001: aluresult = SrcA - SrcB;
      3'b010: aluresult = SrcA & SrcB;
      3'b011: aluresult = SrcA | SrcB;
      3'b100: aluresult = SrcA >> SrcB[4:0];
      3'b101: aluresult = {31'd0, $signed(SrcA) < $signed(SrcB)};
      3'b110: aluresult = SrcA ^ SrcB;
      default: aluresult = SrcA << SrcB[4:0];
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after DONE.
  task automatic mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input int n, input logic [31:0] exp_p, input bit poke);
    int k, nbusy, ndone;
    chk({tag, " ready"}, 32'(ready), 32'd1);
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; op_a = '0; op_b = '0;
    k = 0; nbusy = 0; ndone = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (busy) nbusy++;
      if (a == 32'd7 && k == 1) begin
        chk({tag, " run aluctl"}, 32'(ALUControl), 32'd0);
        chk({tag, " run srcb1"}, SrcB, 32'd0);
      end
      if (a == 32'd7 && k == 2) chk({tag, " run srcb2"}, SrcB, 32'd14);
      start = (poke && k == 2);
      if (done) begin
        ndone++;
        break;
      end
    end
    start = 1'b0;
    chk({tag, " done cycle"}, 32'(k), 32'(n + 1));
    chk({tag, " busy cycles"}, 32'(nbusy), 32'(n + 1));
    chk({tag, " product"}, product, exp_p);
    @(negedge clk);
    chk({tag, " ready after"}, 32'(ready), 32'd1);
    if (poke) begin
      for (int i = 0; i < 8; i++) begin
        if (done || busy) ndone++;
        @(negedge clk);
      end
      chk({tag, " one done"}, 32'(ndone), 32'd1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    ExSrcA = 32'd5; ExSrcB = 32'd5; ExALUControl = 3'b001;
    #1;
    chk("rst ready", 32'(ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst product", product, 32'd0);
    chk("rst srca", SrcA, 32'd5);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    ExSrcA = 32'hA5A5_0001; ExSrcB = 32'h0000_0033; ExALUControl = 3'b110;
    #1;
    chk("pass srca", SrcA, 32'hA5A5_0001);
    chk("pass srcb", SrcB, 32'h0000_0033);
    chk("pass aluctl", 32'(ALUControl), 32'd6);
    ExSrcA = 32'd5; ExSrcB = 32'd5; ExALUControl = 3'b001;
    @(negedge clk);

    mul("7x6", 32'd7, 32'd6, 3, 32'd42, 1'b0);
    mul("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'h0000_0001, 1'b0);
    mul("x0", 32'h0000_1234, 32'd0, 1, 32'd0, 1'b0);
    mul("m3x5", 32'hFFFF_FFFD, 32'd5, 3, 32'hFFFF_FFF1, 1'b1);

    // Reset during the 5th RUN cycle; product was nonzero before.
    start = 1'b1; op_a = 32'd11; op_b = 32'h8000_0000;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("pre-rst busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid-rst busy", 32'(busy), 32'd0);
    chk("mid-rst ready", 32'(ready), 32'd1);
    chk("mid-rst done", 32'(done), 32'd0);
    chk("mid-rst product", product, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mul("3x3", 32'd3, 32'd3, 2, 32'd9, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Iterative shift-add multiply sequencer sharing the EX-stage `alu` of the pipelined core. When idle it passes the pipeline's ALU operands and control straight through. On a multiply request it takes ownership of the ALU, issues one add per multiplier bit, and returns the low 32 bits of the product. It asserts `busy` so hazard control stalls the pipeline while it owns the ALU.

## Interface
- `EARLY_EXIT`, default 1: 1 means stop as soon as the remaining multiplier bits are all zero; 0 means always run 32 iterations.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: multiply request; accepted only when `ready`=1.
- `op_a` in 32: multiplicand, sampled on the accepting edge.
- `op_b` in 32: multiplier, sampled on the accepting edge.
- `ready` out 1: sequencer idle and able to accept `start`.
- `busy` out 1: sequencer owns the ALU; pipeline must stall.
- `done` out 1: one-cycle pulse; `product` is valid.
- `product` out 32: low word of `op_a*op_b`; held until the next accepted `start`.
- `ExSrcA` in 32, `ExSrcB` in 32, `ExALUControl` in 3: pipeline's ALU request.
- `SrcA` out 32, `SrcB` out 32, `ALUControl` out 3: to the `alu` instance.
- `aluresult` in 32: from the `alu` instance.

## Operation
- ALU codes: ADD=000, SUB=001, AND=010, OR=011, SRL=100, SLT=101, XOR=110, SLL=111. The sequencer only issues ADD.
- Internal registers: `M` (32 bits), `Q` (32 bits), `P` (32 bits), `cnt` (5 bits), `state`.
- States are IDLE, RUN and DONE.
- **IDLE**
  - `ready`=1, `busy`=0.
  - ALU outputs are combinational copies of the `Ex*` inputs.
  - `start`=1 loads `M`=`op_a`, `Q`=`op_b`, `P`=0 and `cnt`=0, then moves to RUN.
- **RUN**
  - `ready`=0, `busy`=1.
  - ALU is driven with `SrcA`=`P`, `SrcB`=(`Q[0]` ? `M` : 0) and `ALUControl`=000. `Ex*` inputs are ignored.
  - Each edge: `P`<=`aluresult`, `M`<=`M`<<1, `Q`<=`Q`>>1, `cnt`<=`cnt`+1.
  - Exit to DONE when `cnt`==31, or when `EARLY_EXIT`=1 and `Q[31:1]`==0.
  - On that exit edge, `product`<=`aluresult`.
- **DONE**
  - `ready`=0, `busy`=1, `done`=1 for exactly one cycle, then return to IDLE.
  - ALU outputs are driven as in RUN with `SrcB`=0; the result is unused.
- Arithmetic:
  - Modulo 2^32; the high product word is discarded.
  - The low word is identical for signed and unsigned operands, so no sign handling is needed.
- RUN always lasts at least one cycle, including when `op_b`=0.
- `start` while `ready`=0 is ignored, not queued.
- Reset, at any time including mid-RUN: state=IDLE, `M`/`Q`/`P`/`cnt`/`product`=0, `done`=0. Outputs take these values immediately, without waiting for a clock edge.

## Timing
- Start is accepted at edge T0. RUN occupies n cycles, where:
  - n = (index of highest set bit of `op_b`)+1, minimum 1, when `EARLY_EXIT`=1;
  - n = 32 when `EARLY_EXIT`=0.
- `done` is high during cycle T0+n+1; `product` is valid from that cycle onward.
- `busy` is high from T0+1 through the DONE cycle inclusive. `ready` rises the cycle after DONE.
- Back-to-back: `start` in the first IDLE cycle after DONE is accepted.
- Reset values: `ready`=1, `busy`=0, `done`=0, `product`=0. ALU outputs follow the `Ex*` inputs.
- Pass-through is purely combinational, with zero latency in IDLE. There is no combinational path from `aluresult` to any output.

## Structure
- Shared package `alu_pkg` holds:
  - ALU opcode localparams (`ALU_ADD` … `ALU_SLL`);
  - the `mul_state_t` encoding (IDLE/RUN/DONE).
- The `alu` is not instantiated inside this block; the core top level wires `SrcA`/`SrcB`/`ALUControl`/`aluresult` to it.
- No sub-module: the shift registers, counter and output mux are kept inline.

## Test plan
- `op_a`=7, `op_b`=6 → 3 RUN cycles; `done` at T0+4 with `product`=42.
- `op_a`=0xFFFFFFFF, `op_b`=0xFFFFFFFF → 32 RUN cycles; `product`=0x00000001; `busy` high for 33 cycles.
- `op_a`=0x1234, `op_b`=0 → 1 RUN cycle; `product`=0; `done` at T0+2.
- IDLE with `ExSrcA`=5, `ExSrcB`=5, `ExALUControl`=001 → `SrcA`=5, `SrcB`=5, `ALUControl`=001 in the same cycle. During RUN, `ALUControl`=000 regardless of `Ex*`.
- `op_a`=0xFFFFFFFD (−3), `op_b`=5 → `product`=0xFFFFFFF1; a second `start` pulsed mid-RUN is ignored, with exactly one `done` pulse.
- `reset` asserted in RUN cycle 5 → `busy`=0, `ready`=1, `done`=0, `product`=0 immediately. After release, `op_a`=3, `op_b`=3 gives `product`=9.
